branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the IF stage of the 16-bit pipelined CPU. The current pipeline always predicts not-taken and flushes IF/ID and ID/EX when a branch resolves taken in EX/MEM. This block looks up the current PC combinationally and supplies a predicted next PC. It is trained from the resolved branch in EX/MEM and keeps saturating lookup and mispredict statistics for the VGA debug display.

## Interface
- ADDR_W, 16, PC/target width in bits
- ENTRIES, 16, BTB entries; power of two, 2..256
- IDX_W, log2(ENTRIES), index width; index = pc[IDX_W-1:0], tag = pc[ADDR_W-1:IDX_W]
- STAT_W, 16, width of each statistics counter
- CLK  in  1  CPU clock (CPU_CLK domain); all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- bp_enable  in  1  0 forces pred_taken=0 (static not-taken); training continues
- flush  in  1  invalidate all entries this cycle
- if_pc  in  ADDR_W  PC being fetched
- pred_hit  out  1  valid entry with matching tag at if_pc
- pred_taken  out  1  pred_hit & counter[1] & bp_enable
- pred_target  out  ADDR_W  stored target on hit, else if_pc+1
- upd_valid  in  1  resolved branch present in EX/MEM this cycle
- upd_pc  in  ADDR_W  PC of resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe with this branch
- upd_pred_target  in  ADDR_W  predicted target carried down the pipe
- mispredict  out  1  combinational: upd_valid & (upd_taken != upd_pred_taken | (upd_taken & upd_target != upd_pred_target))
- stat_lookups  out  STAT_W  count of upd_valid cycles, saturating
- stat_mispredicts  out  STAT_W  count of mispredict cycles, saturating

## Operation
- Entry state: valid, tag (ADDR_W-IDX_W bits), target (ADDR_W), ctr (2 bits). Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup is purely combinational from the entry registers. There is no lookup state.
- Update when upd_valid=1, indexed by upd_pc:
  - Hit and upd_taken: ctr saturating +1; target <= upd_target.
  - Hit and not taken: ctr saturating −1; target unchanged.
  - Miss and upd_taken: allocate (replace unconditionally). valid=1, tag from upd_pc, target=upd_target, ctr=10.
  - Miss and not taken: no change.
- Statistics update: stat_lookups +1 on upd_valid; stat_mispredicts +1 on mispredict. Each holds at 2^STAT_W−1.
- Priority per edge: RST > flush > update.
  - flush clears all valid bits and drops a same-cycle update.
  - flush does not touch ctr, target or the statistics.
- Reset: all valid=0, ctr=01, target=0, both stats=0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+1, mispredict follows its inputs.
  - Reset during any activity takes effect at that edge; a same-cycle update is discarded.

## Timing
- Lookup latency 0: pred_* are valid in the same cycle as if_pc.
- Update latency 1: an update at edge N is visible to lookups from cycle N+1 onward.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents (read-before-write).
- if_pc+1 wraps modulo 2^ADDR_W (0xFFFF -> 0x0000).
- Aliasing: PCs with equal index and different tag miss. Only an allocate on a taken update evicts an entry.
- No handshake: the block is not stalled. The caller holds if_pc during PCWrite stalls, and outputs track if_pc.

## Test plan
- Reset, then if_pc=0x0012 -> pred_hit=0, pred_taken=0, pred_target=0x0013. Both stats=0.
- Update pc=0x0012, taken, target=0x0020, pred_taken=0. Next cycle:
  - mispredict=1 during the update cycle.
  - Lookup 0x0012 -> hit, taken, target 0x0020.
  - Lookup 0x0022 (same index, different tag) -> miss, target 0x0023.
  - stat_lookups=1, stat_mispredicts=1.
- Counter walk on 0x0012 (ctr=10):
  - Not taken ×3 -> ctr 01, 00, 00: pred_taken=0 with pred_hit=1.
  - Then taken ×2 -> ctr 01, then 10: pred_taken=1.
- Same-cycle update and lookup of 0x0034 (empty entry, taken) -> miss that cycle, hit the next.
- bp_enable=0 with a hit at ctr=11 -> pred_taken=0, pred_hit=1. flush -> next cycle pred_hit=0 and stats unchanged.
- STAT_W=4, 20 consecutive mispredicting updates -> both stats read 15.
- RST asserted in the same cycle as an update -> entry not written, stats 0.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Combinational lookup of the fetch PC, trained from the resolved branch
// in EX/MEM, plus saturating lookup/mispredict statistics for debug display.
module branch_target_predictor #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int STAT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bp_enable,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_if_pc,
  output logic              o_pred_hit,
  output logic              o_pred_taken,
  output logic [ADDR_W-1:0] o_pred_target,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target,
  input  logic              i_upd_pred_taken,
  input  logic [ADDR_W-1:0] i_upd_pred_target,
  output logic              o_mispredict,
  output logic [STAT_W-1:0] o_stat_lookups,
  output logic [STAT_W-1:0] o_stat_mispredicts
);

  localparam int TAG_W = ADDR_W - IDX_W;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [STAT_W-1:0]  r_stat_lookups;
  logic [STAT_W-1:0]  r_stat_mispredicts;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_if_hit;
  logic             w_upd_hit;
  logic [1:0]       w_upd_ctr;
  logic [1:0]       w_ctr_inc;
  logic [1:0]       w_ctr_dec;

  assign w_if_idx  = i_if_pc[IDX_W-1:0];
  assign w_if_tag  = i_if_pc[ADDR_W-1:IDX_W];
  assign w_upd_idx = i_upd_pc[IDX_W-1:0];
  assign w_upd_tag = i_upd_pc[ADDR_W-1:IDX_W];

  // Lookup reads register contents only, so a same-cycle update is not seen.
  always_comb begin
    w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    o_pred_hit    = w_if_hit;
    o_pred_taken  = w_if_hit && r_ctr[w_if_idx][1] && i_bp_enable;
    o_pred_target = w_if_hit ? r_target[w_if_idx] : (i_if_pc + ADDR_W'(1));
  end

  // Resolve-side decode: hit check and saturating counter neighbours.
  always_comb begin
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    w_upd_ctr = r_ctr[w_upd_idx];
    w_ctr_inc = (w_upd_ctr == 2'b11) ? 2'b11 : (w_upd_ctr + 2'd1);
    w_ctr_dec = (w_upd_ctr == 2'b00) ? 2'b00 : (w_upd_ctr - 2'd1);
    o_mispredict = i_upd_valid &&
                   ((i_upd_taken != i_upd_pred_taken) ||
                    (i_upd_taken && (i_upd_target != i_upd_pred_target)));
  end

  // Entry training; flush only clears valid bits and swallows the update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        if (i_upd_taken) begin
          r_ctr[w_upd_idx]    <= w_ctr_inc;
          r_target[w_upd_idx] <= i_upd_target;
        end else begin
          r_ctr[w_upd_idx] <= w_ctr_dec;
        end
      end else if (i_upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_ctr[w_upd_idx]    <= CTR_ALLOC;
      end
    end
  end

  // Saturating statistics; they count resolved branches even across a flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_lookups     <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (i_upd_valid && (r_stat_lookups != '1))
        r_stat_lookups <= r_stat_lookups + STAT_W'(1);
      if (o_mispredict && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
    end
  end

  assign o_stat_lookups     = r_stat_lookups;
  assign o_stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed test-plan steps followed by
// random traffic, all checked against an array-based behavioural model.
module tb_branch_target_predictor;

  localparam int ADDR_W  = 16;
  localparam int ENTRIES = 16;
  localparam int STAT_W  = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, bp_enable, flush;
  logic [ADDR_W-1:0] if_pc;
  logic              pred_hit, pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid, upd_taken, upd_pred_taken;
  logic [ADDR_W-1:0] upd_pc, upd_target, upd_pred_target;
  logic              mispredict;
  logic [STAT_W-1:0] stat_lookups, stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_lookups, m_misp;

  branch_target_predictor #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .STAT_W(STAT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_bp_enable(bp_enable), .i_flush(flush),
    .i_if_pc(if_pc), .o_pred_hit(pred_hit), .o_pred_taken(pred_taken),
    .o_pred_target(pred_target), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_taken(upd_taken), .i_upd_target(upd_target),
    .i_upd_pred_taken(upd_pred_taken), .i_upd_pred_target(upd_pred_target),
    .o_mispredict(mispredict), .o_stat_lookups(stat_lookups),
    .o_stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_lookups = 0; m_misp = 0;
  endfunction

  function automatic bit m_hit(input int pc);
    return m_valid[pc % ENTRIES] && (m_tag[pc % ENTRIES] == pc / ENTRIES);
  endfunction

  function automatic bit m_mispredict();
    if (!upd_valid) return 0;
    if (upd_taken != upd_pred_taken) return 1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  // model of one rising edge, using the inputs presented this cycle
  function automatic void m_edge();
    int idx, tg;
    bit mis;
    mis = m_mispredict();
    if (rst) begin
      m_reset();
      return;
    end
    if (upd_valid) m_lookups = (m_lookups < STAT_MAX) ? m_lookups + 1 : STAT_MAX;
    if (mis) m_misp = (m_misp < STAT_MAX) ? m_misp + 1 : STAT_MAX;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      return;
    end
    if (!upd_valid) return;
    idx = int'(upd_pc) % ENTRIES;
    tg  = int'(upd_pc) / ENTRIES;
    if (m_hit(int'(upd_pc))) begin
      if (upd_taken) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_tgt[idx] = int'(upd_target);
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (upd_taken) begin
      m_valid[idx] = 1; m_tag[idx] = tg; m_tgt[idx] = int'(upd_target); m_ctr[idx] = 2;
    end
  endfunction

  task automatic settle();
    #3;
  endtask

  // compare every output against the model, then advance one edge
  task automatic cyc();
    int pc, idx;
    bit h;
    pc  = int'(if_pc);
    idx = pc % ENTRIES;
    h   = m_hit(pc);
    chk("m_hit", int'(pred_hit), int'(h));
    chk("m_taken", int'(pred_taken), int'(h && m_ctr[idx] >= 2 && bp_enable));
    chk("m_target", int'(pred_target), h ? m_tgt[idx] : ((pc + 1) % 65536));
    chk("m_mispredict", int'(mispredict), int'(m_mispredict()));
    chk("m_lookups", int'(stat_lookups), m_lookups);
    chk("m_misp", int'(stat_mispredicts), m_misp);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; bp_enable = 1; upd_valid = 0; upd_taken = 0;
    upd_pc = '0; upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0;
  endtask

  task automatic set_upd(input int pc, input bit tk, input int tgt, input bit ptk);
    upd_valid = 1; upd_pc = ADDR_W'(pc); upd_taken = tk;
    upd_target = ADDR_W'(tgt); upd_pred_taken = ptk; upd_pred_target = '0;
  endtask

  initial begin
    idle_inputs();
    if_pc = 16'h0012;
    m_reset();
    @(posedge clk); #1;
    rst = 1;
    settle();
    @(posedge clk); m_edge(); #1;
    rst = 0;

    // reset state
    settle();
    chk("rst_hit", int'(pred_hit), 0);
    chk("rst_taken", int'(pred_taken), 0);
    chk("rst_target", int'(pred_target), 'h13);
    chk("rst_lookups", int'(stat_lookups), 0);
    chk("rst_misp", int'(stat_mispredicts), 0);
    cyc();

    // first allocate, read-before-write on the same PC
    set_upd('h12, 1, 'h20, 0);
    settle();
    chk("alloc_mispredict", int'(mispredict), 1);
    chk("alloc_same_cycle_hit", int'(pred_hit), 0);
    cyc();
    upd_valid = 0;
    settle();
    chk("alloc_hit", int'(pred_hit), 1);
    chk("alloc_taken", int'(pred_taken), 1);
    chk("alloc_target", int'(pred_target), 'h20);
    chk("alloc_lookups", int'(stat_lookups), 1);
    chk("alloc_misp", int'(stat_mispredicts), 1);
    cyc();
    if_pc = 16'h0022;
    settle();
    chk("alias_hit", int'(pred_hit), 0);
    chk("alias_target", int'(pred_target), 'h23);
    cyc();

    // counter walk down to strong NT and back up
    if_pc = 16'h0012;
    for (int i = 0; i < 3; i++) begin
      set_upd('h12, 0, 0, 0);
      settle(); cyc();
      upd_valid = 0;
      settle();
      chk("walk_nt_hit", int'(pred_hit), 1);
      chk("walk_nt_taken", int'(pred_taken), 0);
      cyc();
    end
    set_upd('h12, 1, 'h20, 0);
    settle(); cyc();
    upd_valid = 0;
    settle();
    chk("walk_t1_taken", int'(pred_taken), 0);
    cyc();
    set_upd('h12, 1, 'h20, 0);
    settle(); cyc();
    upd_valid = 0;
    settle();
    chk("walk_t2_taken", int'(pred_taken), 1);
    cyc();

    // same-cycle update and lookup of an empty entry
    if_pc = 16'h0034;
    set_upd('h34, 1, 'h50, 0);
    settle();
    chk("rbw_miss", int'(pred_hit), 0);
    cyc();
    upd_valid = 0;
    settle();
    chk("rbw_hit_next", int'(pred_hit), 1);
    chk("rbw_target", int'(pred_target), 'h50);
    cyc();

    // strong taken, then bp_enable=0 and flush
    set_upd('h34, 1, 'h50, 1);
    upd_pred_target = 16'h0050;
    settle(); cyc();
    upd_valid = 0; bp_enable = 0;
    settle();
    chk("bpdis_hit", int'(pred_hit), 1);
    chk("bpdis_taken", int'(pred_taken), 0);
    cyc();
    bp_enable = 1; flush = 1;
    settle(); cyc();
    flush = 0;
    settle();
    chk("flush_hit", int'(pred_hit), 0);
    cyc();

    // statistics saturation
    for (int i = 0; i < 20; i++) begin
      set_upd('h60 + i, 1, 'h100 + i, 0);
      settle(); cyc();
    end
    upd_valid = 0;
    settle();
    chk("sat_lookups", int'(stat_lookups), 15);
    chk("sat_misp", int'(stat_mispredicts), 15);
    cyc();

    // flush drops a same-cycle allocate
    set_upd('h77, 1, 'h200, 0);
    flush = 1;
    settle(); cyc();
    flush = 0; upd_valid = 0; if_pc = 16'h0077;
    settle();
    chk("flush_drop_hit", int'(pred_hit), 0);
    cyc();

    // reset in the same cycle as an update
    rst = 1;
    set_upd('h12, 1, 'h99, 0);
    settle(); cyc();
    rst = 0; upd_valid = 0; if_pc = 16'h0012;
    settle();
    chk("rstupd_hit", int'(pred_hit), 0);
    chk("rstupd_target", int'(pred_target), 'h13);
    chk("rstupd_lookups", int'(stat_lookups), 0);
    chk("rstupd_misp", int'(stat_mispredicts), 0);
    cyc();

    // PC wrap
    if_pc = 16'hFFFF;
    settle();
    chk("wrap_target", int'(pred_target), 0);
    cyc();

    // random traffic on a small PC pool so entries hit, alias and evict
    for (int n = 0; n < 600; n++) begin
      int r;
      idle_inputs();
      r = int'($urandom_range(0, 99));
      if (r < 2) rst = 1;
      else if (r < 7) flush = 1;
      bp_enable = ($urandom_range(0, 9) != 0);
      if_pc = ($urandom_range(0, 19) == 0) ? ADDR_W'($urandom)
              : ADDR_W'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      if (!flush && $urandom_range(0, 2) != 0) begin
        upd_valid = 1;
        upd_pc = ($urandom_range(0, 1) == 0) ? if_pc
                 : ADDR_W'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
        upd_taken = 1'($urandom);
        upd_target = ADDR_W'($urandom_range(0, 7));
        upd_pred_taken = 1'($urandom);
        upd_pred_target = ($urandom_range(0, 1) == 0) ? upd_target
                          : ADDR_W'($urandom_range(0, 7));
      end
      settle();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
